// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Holds formats, opcodes, FSM states and immediate range limits.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R      = 3'd0,
        FMT_I      = 3'd1,
        FMT_LOAD   = 3'd2,
        FMT_STORE  = 3'd3,
        FMT_BRANCH = 3'd4,
        FMT_JAL    = 3'd5,
        FMT_JALR   = 3'd6,
        FMT_RSVD   = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

    typedef struct packed {
        fmt_e        fmt;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    function automatic logic in_range(
        input logic [31:0] v,
        input int          lo,
        input int          hi
    );
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field input, memory write port and status signals of the encoder.
// The master side drives fields and mem_ack; the slave side is the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 12
);
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic              err;
    logic [15:0]       wr_count;

    modport master (
        output base_load, base_addr, in_valid,
        output fmt, funct3, funct7, rd, rs1, rs2, imm,
        output mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  err, wr_count
    );

    modport slave (
        input  base_load, base_addr, in_valid,
        input  fmt, funct3, funct7, rd, rs1, rs2, imm,
        input  mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output err, wr_count
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: builds the 32-bit word and checks that
// the immediate fits the chosen format.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        unique case (f.fmt)
            FMT_R: begin
                word  = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, OP_R};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {f.imm[11:0], f.rs1, f.funct3, f.rd, OP_I};
                legal = in_range(f.imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_LOAD: begin
                word  = {f.imm[11:0], f.rs1, f.funct3, f.rd, OP_LOAD};
                legal = in_range(f.imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_STORE: begin
                word  = {f.imm[11:5], f.rs2, f.rs1, f.funct3,
                         f.imm[4:0], OP_STORE};
                legal = in_range(f.imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_BRANCH: begin
                word  = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                         f.imm[4:1], f.imm[11], OP_BRANCH};
                legal = in_range(f.imm, IMM13_MIN, IMM13_MAX)
                        && !f.imm[0];
            end
            FMT_JAL: begin
                word  = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                         f.rd, OP_JAL};
                legal = in_range(f.imm, IMM21_MIN, IMM21_MAX)
                        && !f.imm[0];
            end
            FMT_JALR: begin
                // funct3 is architecturally fixed to zero for JALR
                word  = {f.imm[11:0], f.rs1, 3'b000, f.rd, OP_JALR};
                legal = in_range(f.imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_RSVD: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: captures fields, encodes them, and writes the
// word to instruction memory at an auto-incrementing byte pointer.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input logic             clk,
    input logic             rst,
    instr_encoder_if.slave  bus
);

    state_e            state;
    state_e            nxt;
    fields_t           fld;
    logic [31:0]       word;
    logic              legal;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] ptr;
    logic [15:0]       cnt;

    instr_pack u_pack (
        .f     (fld),
        .word  (word),
        .legal (legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt          = state;
        bus.in_ready = 1'b0;
        bus.mem_we   = 1'b0;
        bus.err      = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) nxt = S_ENC;
            end
            S_ENC: begin
                nxt = legal ? S_WR : S_ERR;
            end
            S_WR: begin
                bus.mem_we = 1'b1;
                if (bus.mem_ack) nxt = S_IDLE;
            end
            S_ERR: begin
                bus.err = 1'b1;
                nxt     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fld   <= '0;
            wdata <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            if (state == S_IDLE) begin
                // word alignment: low two address bits are dropped
                if (bus.base_load)
                    ptr <= bus.base_addr & ~ADDR_W'(3);
                if (bus.in_valid) begin
                    fld <= '{fmt:    fmt_e'(bus.fmt),
                             funct3: bus.funct3,
                             funct7: bus.funct7,
                             rd:     bus.rd,
                             rs1:    bus.rs1,
                             rs2:    bus.rs2,
                             imm:    bus.imm};
                end
            end
            if (state == S_ENC)
                wdata <= word;
            if (state == S_WR && bus.mem_ack) begin
                ptr <= ptr + ADDR_W'(4);
                if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            end
        end
    end

    assign bus.mem_addr  = ptr;
    assign bus.mem_wdata = wdata;
    assign bus.wr_count  = cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued when
// fields are driven and matched when the memory write completes.
module tb_instr_encoder;

    localparam int AW = 12;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          sb[$];
    exp_t          mon_e;
    int            vectors    = 0;
    int            miscompares = 0;
    logic [AW-1:0] exp_ptr    = '0;
    logic [15:0]   exp_count  = '0;

    always @(negedge clk) begin
        #1;
        if (!rst && bus.mem_we === 1'b1 && bus.mem_ack === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got addr %h data %h want none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_e = sb.pop_front();
                if (bus.mem_addr !== mon_e.addr ||
                    bus.mem_wdata !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL sb_write: got %h@%h want %h@%h",
                             bus.mem_wdata, bus.mem_addr,
                             mon_e.data, mon_e.addr);
                end
            end
        end
    end

    function automatic void expect_wr(input logic [31:0] w);
        exp_t e;
        e.addr = exp_ptr;
        e.data = w;
        sb.push_back(e);
        exp_ptr   = exp_ptr + AW'(4);
        exp_count = exp_count + 16'd1;
    endfunction

    task automatic drive(
        input logic [2:0]    f,
        input logic [2:0]    f3,
        input logic [6:0]    f7,
        input logic [4:0]    d,
        input logic [4:0]    s1,
        input logic [4:0]    s2,
        input logic [31:0]   im,
        input logic          bl = 1'b0,
        input logic [AW-1:0] ba = '0
    );
        int n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_wait: got %b want 1", bus.in_ready);
            return;
        end
        bus.fmt       = f;
        bus.funct3    = f3;
        bus.funct7    = f7;
        bus.rd        = d;
        bus.rs1       = s1;
        bus.rs2       = s2;
        bus.imm       = im;
        bus.base_load = bl;
        bus.base_addr = ba;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.base_load = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.in_ready !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        vectors++;
        if (bus.wr_count !== exp_count || bus.mem_addr !== exp_ptr) begin
            miscompares++;
            $display("FAIL drain_state: got cnt %0d ptr %h want %0d %h",
                     bus.wr_count, bus.mem_addr, exp_count, exp_ptr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.err !== 1'b0 ||
            bus.mem_wdata !== 32'h0 || bus.wr_count !== 16'h0 ||
            bus.mem_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: got we %b err %b wd %h cnt %h a %h want 0",
                     bus.mem_we, bus.err, bus.mem_wdata, bus.wr_count,
                     bus.mem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_r_type();
        bus.mem_ack = 1'b1;
        expect_wr(32'h00B00533);
        drive(3'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd11, 32'd0);
        drain();
    endtask

    task automatic test_back_to_back();
        expect_wr(32'h02000513);
        expect_wr(32'h00A5A023);
        expect_wr(32'h00B50263);
        expect_wr(32'hFEDFF0EF);
        expect_wr(32'h004580E7);
        drive(3'd1, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'd32);
        drive(3'd3, 3'd2, 7'd0, 5'd0, 5'd11, 5'd10, 32'd0);
        drive(3'd4, 3'd0, 7'd0, 5'd0, 5'd10, 5'd11, 32'd4);
        drive(3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd20);
        drive(3'd6, 3'd5, 7'd0, 5'd1, 5'd11, 5'd0, 32'd4);
        drain();
    endtask

    task automatic test_boundaries();
        expect_wr(32'h80000063);
        expect_wr(32'h7FF00013);
        expect_wr(32'h8000006F);
        expect_wr(32'h80000023);
        drive(3'd4, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4096);
        drive(3'd1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2047);
        drive(3'd5, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd1048576);
        drive(3'd3, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd2048);
        drain();
    endtask

    task automatic test_reject();
        logic [2:0]  fmts [5] = '{3'd4, 3'd1, 3'd7, 3'd5, 3'd3};
        logic [31:0] imms [5] = '{32'd3, 32'd2048, 32'd0,
                                  32'd1048575, 32'hFFFFF7FF};
        for (int k = 0; k < 5; k++) begin
            int errs = 0;
            int wes  = 0;
            drive(fmts[k], 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, imms[k]);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (bus.err === 1'b1) errs++;
                if (bus.mem_we === 1'b1) wes++;
            end
            vectors++;
            if (errs != 1 || wes != 0) begin
                miscompares++;
                $display("FAIL reject_%0d: got err %0d we %0d want 1 0",
                         k, errs, wes);
            end
            vectors++;
            if (bus.wr_count !== exp_count || bus.mem_addr !== exp_ptr) begin
                miscompares++;
                $display("FAIL reject_state_%0d: got %0d %h want %0d %h",
                         k, bus.wr_count, bus.mem_addr, exp_count, exp_ptr);
            end
        end
    endtask

    task automatic test_delayed_ack();
        logic [AW-1:0] a;
        a = exp_ptr;
        bus.mem_ack = 1'b0;
        expect_wr(32'hFFC12283);
        drive(3'd2, 3'd2, 7'd0, 5'd5, 5'd2, 5'd0, -32'sd4);
        vectors++;
        if (bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_enc: got we %b want 0", bus.mem_we);
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== a ||
                bus.mem_wdata !== 32'hFFC12283 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_%0d: got we %b %h@%h rdy %b want 1 %h@%h 0",
                         i, bus.mem_we, bus.mem_wdata, bus.mem_addr,
                         bus.in_ready, 32'hFFC12283, a);
            end
            // base_load while writing must not move the pointer
            bus.base_load = (i == 1);
            bus.base_addr = AW'(12'h200);
            if (i == 5) bus.mem_ack = 1'b1;
            @(negedge clk);
        end
        bus.base_load = 1'b0;
        vectors++;
        if (bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: got we %b want 0", bus.mem_we);
        end
        drain();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        bus.base_load = 1'b1;
        bus.base_addr = AW'(12'hFFF);
        @(negedge clk);
        bus.base_load = 1'b0;
        exp_ptr = AW'(12'hFFC);
        vectors++;
        if (bus.mem_addr !== exp_ptr) begin
            miscompares++;
            $display("FAIL base_load: got %h want %h", bus.mem_addr, exp_ptr);
        end
        expect_wr(32'h00100093);
        expect_wr(32'h002081B3);
        drive(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        drive(3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        drain();
    endtask

    task automatic test_coincide();
        exp_ptr = AW'(12'h100);
        expect_wr(32'h00100093);
        drive(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1,
              1'b1, AW'(12'h101));
        drain();
    endtask

    task automatic test_reset_mid_wr();
        bus.mem_ack = 1'b0;
        expect_wr(32'h00100093);
        drive(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst_we: got %b want 1", bus.mem_we);
        end
        rst = 1'b1;
        #1;
        sb.delete();
        exp_ptr   = '0;
        exp_count = '0;
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.err !== 1'b0 ||
            bus.mem_wdata !== 32'h0 || bus.wr_count !== 16'h0 ||
            bus.mem_addr !== '0) begin
            miscompares++;
            $display("FAIL rst_mid: got we %b err %b wd %h cnt %h a %h want 0",
                     bus.mem_we, bus.err, bus.mem_wdata, bus.wr_count,
                     bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.wr_count !== 16'h0 || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL late_ack: got cnt %0d we %b want 0 0",
                     bus.wr_count, bus.mem_we);
        end
        expect_wr(32'h00100093);
        drive(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.base_load = 1'b0;
        bus.base_addr = '0;
        bus.in_valid  = 1'b0;
        bus.fmt       = '0;
        bus.funct3    = '0;
        bus.funct7    = '0;
        bus.rd        = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.imm       = '0;
        bus.mem_ack   = 1'b0;
        test_reset();
        test_r_type();
        test_back_to_back();
        test_boundaries();
        test_reject();
        test_delayed_ack();
        test_wrap();
        test_coincide();
        test_reset_mid_wr();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
